// File: rtl/reloj_pio_in_if.sv
// Avalon-MM register bus between the interconnect and the clock's input PIO.
// The interconnect drives address, strobes and write data; the PIO returns read data.
interface reloj_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/reloj_pio_in.sv
// Input PIO for the alarm clock: synchronises and debounces the button inputs,
// captures their rising edges and raises a maskable interrupt.
module reloj_pio_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    localparam int DB_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    reloj_pio_in_if.slave        bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [DB_W-1:0]  cnt_q [WIDTH];
    logic [DB_W-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic             wr_en;

    assign wr_en = bus.chipselect && !bus.write_n;

    // A bit only follows its input after it has differed for a full window.
    always_comb begin
        deb_d = deb_q;
        rise  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                    rise[i]  = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        if (wr_en && bus.address == 2'd3) begin
            clr = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == 2'd2) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        // A rise in the same cycle as its clear keeps the bit set.
        cap_d = (cap_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cap_q   <= '0;
            mask_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = 32'(deb_q);
            2'd2:    bus.readdata = 32'(mask_q);
            2'd3:    bus.readdata = 32'(cap_q);
            default: bus.readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_reloj_pio_in.sv
// Directed bench for reloj_pio_in with a short debounce window.
// Each step advances one clock and checks register reads against hand values.
module tb_reloj_pio_in;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_port;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    reloj_pio_in_if bus ();

    reloj_pio_in #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic rchk(input string tag, input logic [1:0] a,
                        input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    // Write is sampled on the next rising edge, then released.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    initial begin
        logic [31:0] d;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        in_port        = '0;
        reset          = 1'b1;
        tick(3);
        reset = 1'b0;

        rchk("rst_a0", 2'd0, 32'h0);
        rchk("rst_a1", 2'd1, 32'h0);
        rchk("rst_a2", 2'd2, 32'h0);
        rchk("rst_a3", 2'd3, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        in_port = 8'h01;
        tick(5);
        rchk("b0_early_a0", 2'd0, 32'h0);
        rchk("b0_early_a3", 2'd3, 32'h0);
        tick(1);
        rchk("b0_a0", 2'd0, 32'h01);
        rchk("b0_a3", 2'd3, 32'h01);
        chk("b0_irq", 32'(irq), 32'h0);

        in_port = 8'h05;
        tick(3);
        in_port = 8'h01;
        for (int i = 0; i < 10; i++) begin
            rd(2'd0, d);
            chk("glitch_a0", d, 32'h01);
            rd(2'd3, d);
            chk("glitch_a3", d, 32'h01);
            tick(1);
        end

        in_port = 8'h05;
        tick(6);
        rchk("pulse_a0", 2'd0, 32'h05);
        rchk("pulse_a3", 2'd3, 32'h05);
        in_port = 8'h01;
        tick(5);
        rchk("fall_hold_a0", 2'd0, 32'h05);
        tick(1);
        rchk("fall_a0", 2'd0, 32'h01);
        rchk("fall_a3", 2'd3, 32'h05);

        wr(2'd2, 32'h05);
        rchk("mask_a2", 2'd2, 32'h05);
        chk("mask_irq", 32'(irq), 32'h1);
        wr(2'd3, 32'h01);
        rchk("clr0_a3", 2'd3, 32'h04);
        chk("clr0_irq", 32'(irq), 32'h1);
        wr(2'd3, 32'h04);
        rchk("clr2_a3", 2'd3, 32'h00);
        chk("clr2_irq", 32'(irq), 32'h0);
        rchk("noside_a3", 2'd3, 32'h00);

        in_port = 8'h09;
        tick(5);
        rchk("race_pre_a0", 2'd0, 32'h01);
        wr(2'd3, 32'h08);
        rchk("race_a0", 2'd0, 32'h09);
        rchk("race_a3", 2'd3, 32'h08);
        chk("race_irq", 32'(irq), 32'h0);

        in_port = 8'h29;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rchk("mid_a0", 2'd0, 32'h00);
        rchk("mid_a2", 2'd2, 32'h00);
        rchk("mid_a3", 2'd3, 32'h00);
        chk("mid_irq", 32'(irq), 32'h0);
        tick(5);
        rchk("mid_early_a0", 2'd0, 32'h00);
        tick(1);
        rchk("mid_a0_up", 2'd0, 32'h29);
        rchk("mid_a3_up", 2'd3, 32'h29);
        rchk("mid_a1", 2'd1, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
